multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the datapath. It replaces single-cycle decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback.
- It drives the same 4-bit-opcode control set as the single-cycle CONTROL unit, plus PC, IR and memory-interface strobes.
- It sits between the shared unified memory port (valid/ready handshake) and the register file, ALU and PC registers.

Parameters:
- CNT_W, 32, width of the performance counters (only used with PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  4  IR[15:12]; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_read  out  1  memory read request; held until mem_ready.
- mem_write  out  1  memory write request; held until mem_ready.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero (beq).
- pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B operand: 00 = rt, 01 = constant 1, 10 = sign-extended immediate.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct, 11 = logical immediate.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- halted  out  1  high while in HALT.
- state  out  4  current state encoding, for debug.
- cycle_cnt  out  CNT_W  total cycles since reset (PERF_CNT_EN only).
- instr_cnt  out  CNT_W  instructions retired (PERF_CNT_EN only).

Behaviour:
- Opcode map: 0 RTYPE, 1 ADDI, 2 ANDI, 3 ORI, 4 LW, 5 SW, 6 BEQ, 7 J, 8 HALT. Opcodes 9-15 are illegal.
- State encodings:
  - IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, BRANCH = 6, JUMP = 7, HALT = 8.
  - Unused encodings return to IDLE on the next cycle.
- Control outputs are a Moore decode of the state register. The exceptions are ir_write, pc_write in FETCH, and illegal, which are qualified combinationally as stated below.
- Reset: state = IDLE, every output = 0. Reset asserted in any state, including mid memory access, returns to IDLE on the next edge.
- IDLE: all outputs 0. Moves to FETCH on the first clock with rst_n = 1.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
  - ir_write and pc_write are asserted only in the cycle mem_ready = 1.
  - Stays in FETCH while mem_ready = 0; moves to DECODE on mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 10, alu_op = 00 (branch target into ALUOut).
  - Next state: opcodes 0-5 go to EXEC, 6 to BRANCH, 7 to JUMP, 8 to HALT.
  - Illegal opcode: pulses illegal for one cycle and returns to FETCH. The PC is already advanced, so the instruction acts as a no-op.
- EXEC:
  - Operands: alu_src_a = 1. alu_src_b = 00 for RTYPE, otherwise 10.
  - alu_op: 10 for RTYPE, 11 for ANDI/ORI, 00 for ADDI/LW/SW.
  - Next state: LW and SW go to MEM, all others go to WB.
- MEM:
  - Outputs: i_or_d = 1, with mem_read = 1 for LW or mem_write = 1 for SW. The request is held until mem_ready.
  - On mem_ready = 1: LW goes to WB, SW goes to FETCH.
- WB:
  - Outputs: reg_write = 1. reg_dst = 1 only for RTYPE. mem_to_reg = 1 only for LW.
  - Next state: FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_src = 01. Next state: FETCH.
- JUMP: pc_write = 1, pc_src = 10. Next state: FETCH.
- HALT: halted = 1, all other outputs 0. Only reset leaves HALT.
- Latency with mem_ready tied to 1:
  - RTYPE/ADDI/ANDI/ORI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/J: 3 cycles.
- Each memory wait cycle adds one cycle to the instruction.
- mem_read and mem_write are never high together.
- opcode is sampled in DECODE, EXEC, MEM and WB. The IR must not change outside FETCH.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle outside IDLE and HALT.
  - instr_cnt increments on each retiring transition into FETCH (from WB, BRANCH, JUMP, or MEM for SW) and on entry to HALT.
  - Illegal-opcode returns to FETCH are not counted.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: no counter logic; cycle_cnt and instr_cnt are tied to 0.

Test Plan:
- Reset/start: hold rst_n = 0 for 3 clocks, then release -> all outputs 0 during reset and for the IDLE cycle; state = 1 on the next cycle; mem_read = 1.
- RTYPE, ready = 1: opcode 0 -> state sequence 1, 2, 3, 5, 1; in EXEC alu_op = 10, alu_src_b = 00; in WB reg_write = 1, reg_dst = 1, mem_to_reg = 0.
- LW with 2 wait cycles in MEM: opcode 4, mem_ready low for 2 cycles -> MEM lasts 3 cycles with mem_read = 1 and i_or_d = 1 throughout; then WB with mem_to_reg = 1, reg_dst = 0; total 7 cycles.
- BEQ and J: opcode 6 with zero = 1 -> pc_write_cond = 1 and pc_src = 01 in BRANCH, back in FETCH after 3 cycles. Opcode 7 -> pc_write = 1 and pc_src = 10.
- Illegal and halt:
  - Opcode 12 -> illegal pulses 1 cycle in DECODE, then FETCH.
  - Opcode 8 -> halted = 1 held for 20 cycles; a mid-HALT reset returns to IDLE.
- PERF_CNT_EN: run RTYPE, SW, BEQ, HALT with ready = 1 -> instr_cnt = 4, cycle_cnt = 13 (4 + 4 + 3 + 2 cycles); both 0 when the macro is undefined.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/execute/memory/writeback control sequencer
// Optional performance counters are built when PERF_CNT_EN is defined.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ANDI  = 4'd2;
    localparam logic [3:0] OP_ORI   = 4'd3;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_SW    = 4'd5;
    localparam logic [3:0] OP_BEQ   = 4'd6;
    localparam logic [3:0] OP_J     = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd8;

    state_t cur_state;
    state_t nxt_state;

    // The zero flag gates pc_write_cond in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state     = S_IDLE;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal       = 1'b0;
        halted        = 1'b0;
        case (cur_state)
            S_IDLE: nxt_state = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                nxt_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                if (opcode <= OP_SW) begin
                    nxt_state = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    nxt_state = S_BRANCH;
                end else if (opcode == OP_J) begin
                    nxt_state = S_JUMP;
                end else if (opcode == OP_HALT) begin
                    nxt_state = S_HALT;
                end else begin
                    // PC already advanced in FETCH, so dropping back retires nothing.
                    illegal   = 1'b1;
                    nxt_state = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = (opcode == OP_RTYPE) ? 2'b00 : 2'b10;
                if (opcode == OP_RTYPE) begin
                    alu_op = 2'b10;
                end else if (opcode == OP_ANDI || opcode == OP_ORI) begin
                    alu_op = 2'b11;
                end
                nxt_state = (opcode == OP_LW || opcode == OP_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
                if (!mem_ready) begin
                    nxt_state = S_MEM;
                end else begin
                    nxt_state = (opcode == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                mem_to_reg = (opcode == OP_LW);
                nxt_state  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                nxt_state     = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_src    = 2'b10;
                nxt_state = S_FETCH;
            end
            S_HALT: begin
                halted    = 1'b1;
                nxt_state = S_HALT;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

`ifdef PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign retire = ((nxt_state == S_FETCH) &&
                     (cur_state == S_WB || cur_state == S_BRANCH ||
                      cur_state == S_JUMP || cur_state == S_MEM)) ||
                    ((nxt_state == S_HALT) && (cur_state == S_DECODE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (cur_state != S_IDLE && cur_state != S_HALT) begin
                cycle_q <= cycle_q + ONE;
            end
            if (retire) begin
                instr_q <= instr_q + ONE;
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against a per-instruction cycle-list model
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic        alu_src_a, reg_dst, reg_write, mem_to_reg, illegal, halted;
    logic [3:0]  state;
    logic [31:0] cycle_cnt, instr_cnt;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal), .halted(halted),
        .state(state), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       reg_dst, reg_write, mem_to_reg, illegal, halted;
    } ctl_t;

    typedef struct {
        int         st;
        ctl_t       c;
        logic       rdy;
        logic [3:0] op;
        bit         ret;
    } ent_t;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m_cyc = 0;
    int   m_ins = 0;

    function automatic ctl_t observed_ctl();
        ctl_t c;
        c = '{mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
              alu_src_a, alu_src_b, alu_op, reg_dst, reg_write, mem_to_reg, illegal, halted};
        return c;
    endfunction

    function automatic logic [31:0] perf_exp(int v);
`ifdef PERF_CNT_EN
        return v;
`else
        return (v == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_counters();
        chk("cycle_cnt", cycle_cnt, perf_exp(m_cyc));
        chk("instr_cnt", instr_cnt, perf_exp(m_ins));
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_state"}, {28'd0, state}, 32'd0);
        chk({tag, "_ctl"}, {13'd0, observed_ctl()}, 32'd0);
        chk_counters();
    endtask

    task automatic push(int st, ctl_t c, logic rdy, logic [3:0] op, bit ret);
        ent_t e;
        e.st = st; e.c = c; e.rdy = rdy; e.op = op; e.ret = ret;
        q.push_back(e);
    endtask

    // Expected cycle-by-cycle trace of one instruction, straight from the opcode rules.
    task automatic gen(logic [3:0] op, int wf, int wm);
        ctl_t c;
        for (int i = 0; i <= wf; i++) begin
            c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
            c.ir_write = (i == wf); c.pc_write = (i == wf);
            push(1, c, (i == wf), op, 0);
        end
        c = '0; c.alu_src_b = 2'b10; c.illegal = (op > 8);
        push(2, c, 1'($urandom), op, (op == 8));
        if (op > 8) return;
        if (op == 8) begin
            c = '0; c.halted = 1;
            for (int i = 0; i < 20; i++) push(8, c, 1'($urandom), op, 0);
        end else if (op == 6) begin
            c = '0; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_src = 2'b01;
            push(6, c, 1'($urandom), op, 1);
        end else if (op == 7) begin
            c = '0; c.pc_write = 1; c.pc_src = 2'b10;
            push(7, c, 1'($urandom), op, 1);
        end else begin
            c = '0; c.alu_src_a = 1;
            c.alu_src_b = (op == 0) ? 2'b00 : 2'b10;
            c.alu_op = (op == 0) ? 2'b10 : ((op == 2 || op == 3) ? 2'b11 : 2'b00);
            push(3, c, 1'($urandom), op, 0);
            if (op == 4 || op == 5) begin
                for (int i = 0; i <= wm; i++) begin
                    c = '0; c.i_or_d = 1; c.mem_read = (op == 4); c.mem_write = (op == 5);
                    push(4, c, (i == wm), op, (op == 5 && i == wm));
                end
            end
            if (op != 5) begin
                c = '0; c.reg_write = 1; c.reg_dst = (op == 0); c.mem_to_reg = (op == 4);
                push(5, c, 1'($urandom), op, 1);
            end
        end
    endtask

    task automatic run_q();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            opcode = e.op; mem_ready = e.rdy; zero = 1'($urandom);
            #1;
            chk("state", {28'd0, state}, e.st);
            chk("ctl", {13'd0, observed_ctl()}, {13'd0, e.c});
            chk("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
            chk_counters();
            if (e.st != 0 && e.st != 8) m_cyc++;
            if (e.ret) m_ins++;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_quiet("idle");
    endtask

    initial begin
        int v;
        rst_n = 1'b0; opcode = 4'd0; mem_ready = 1'b0; zero = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk_quiet("reset");
        end
        release_reset();

        gen(4'd0, 0, 0);
        gen(4'd4, 0, 2);
        gen(4'd6, 0, 0);
        gen(4'd7, 0, 0);
        gen(4'd12, 0, 0);
        gen(4'd5, 1, 1);
        for (int n = 0; n < 60; n++) begin
            v = $urandom_range(0, 14);
            gen((v >= 8) ? 4'(v + 1) : 4'(v), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        gen(4'd8, 0, 0);
        run_q();

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("halt_before_reset", {28'd0, state}, 32'd8);
        @(negedge clk);
        #1;
        m_cyc = 0; m_ins = 0;
        chk_quiet("mid_halt_reset");
        release_reset();

        gen(4'd0, 0, 0);
        gen(4'd5, 0, 0);
        gen(4'd6, 0, 0);
        gen(4'd8, 0, 0);
        run_q();
`ifdef PERF_CNT_EN
        chk("perf_instr", instr_cnt, 32'd4);
        chk("perf_cycle", cycle_cnt, 32'd13);
`else
        chk("perf_instr", instr_cnt, 32'd0);
        chk("perf_cycle", cycle_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
